// File: rtl/retire_multi.sv
// retire_multi: N-wide in-order retire stage that owns the ROB head pointer.
// Each cycle it commits the longest head-contiguous prefix of completed slots.
// It writes their results to the regfile and serialises stores through a
// request/ack handshake. Halt and illegal instructions stop it until reset, and
// a mispredicted branch produces a flush pulse.
// Optional feature macro: RETIRE_PERF_CNT_EN adds saturating performance
// counters (perf_retired, perf_stall_cycles).
module retire_multi #(
  parameter int RETIRE_WIDTH = 2,
  parameter int ROB_SZ       = 32,
  parameter int XLEN         = 32,
  localparam int IDX_W = $clog2(ROB_SZ),
  localparam int CNT_W = $clog2(RETIRE_WIDTH + 1)
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [RETIRE_WIDTH-1:0]   slot_valid,
  input  logic [RETIRE_WIDTH-1:0]   slot_done,
  input  logic [RETIRE_WIDTH*IDX_W-1:0] slot_rob_idx,
  input  logic [RETIRE_WIDTH*5-1:0] slot_dest_idx,
  input  logic [RETIRE_WIDTH*XLEN-1:0] slot_result,
  input  logic [RETIRE_WIDTH*XLEN-1:0] slot_NPC,
  input  logic [RETIRE_WIDTH-1:0]   slot_halt,
  input  logic [RETIRE_WIDTH-1:0]   slot_illegal,
  input  logic [RETIRE_WIDTH-1:0]   slot_store,
  input  logic [RETIRE_WIDTH-1:0]   slot_mispred,
  input  logic                      store_ack,
  output logic [IDX_W-1:0]          rob_head,
  output logic [CNT_W-1:0]          commit_count,
  output logic [RETIRE_WIDTH-1:0]   rf_wr_en,
  output logic [RETIRE_WIDTH*5-1:0] rf_wr_idx,
  output logic [RETIRE_WIDTH*XLEN-1:0] rf_wr_data,
  output logic                      store_req,
  output logic [IDX_W-1:0]          store_rob_idx,
  output logic                      flush,
  output logic [XLEN-1:0]           commit_NPC,
  output logic [3:0]                completed_insts,
  output logic [1:0]                error_status
`ifdef RETIRE_PERF_CNT_EN
  ,
  output logic [63:0]               perf_retired,
  output logic [63:0]               perf_stall_cycles
`endif
);

  localparam logic [1:0] NO_ERROR      = 2'd0;
  localparam logic [1:0] HALTED_ON_WFI = 2'd1;
  localparam logic [1:0] ILLEGAL_INST  = 2'd2;

  typedef enum logic [1:0] {RUN = 2'd0, STORE_WAIT = 2'd1, HALTED = 2'd2} state_t;

  state_t                     state_q, state_d;
  logic [IDX_W-1:0]           head_q, head_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [RETIRE_WIDTH-1:0]    rf_wr_en_q, rf_wr_en_d;
  logic [RETIRE_WIDTH*5-1:0]  rf_wr_idx_q, rf_wr_idx_d;
  logic [RETIRE_WIDTH*XLEN-1:0] rf_wr_data_q, rf_wr_data_d;
  logic                       store_req_q, store_req_d;
  logic [IDX_W-1:0]           store_rob_idx_q, store_rob_idx_d;
  logic [XLEN-1:0]            store_npc_q, store_npc_d;
  logic                       flush_q, flush_d;
  logic [XLEN-1:0]            commit_npc_q, commit_npc_d;
  logic [1:0]                 error_q, error_d;
  logic                       go;

  // Retire decision: walk the slots from the head, stopping at the first
  // ineligible slot or at the first store/halt/illegal/mispredict.
  always_comb begin
    state_d         = state_q;
    head_d          = head_q;
    cnt_d           = '0;
    rf_wr_en_d      = '0;
    rf_wr_idx_d     = '0;
    rf_wr_data_d    = '0;
    store_req_d     = 1'b0;
    store_rob_idx_d = store_rob_idx_q;
    store_npc_d     = store_npc_q;
    flush_d         = 1'b0;
    commit_npc_d    = '0;
    error_d         = error_q;
    go              = 1'b1;
    case (state_q)
      RUN: begin
        for (int i = 0; i < RETIRE_WIDTH; i++) begin
          if (go) begin
            if (slot_valid[i] && slot_done[i] &&
                slot_rob_idx[i*IDX_W +: IDX_W] == head_q + IDX_W'(i)) begin
              if (slot_store[i]) begin
                // Stores only leave from slot 0, and only after the ack.
                go = 1'b0;
                if (i == 0) begin
                  store_req_d     = 1'b1;
                  store_rob_idx_d = head_q;
                  store_npc_d     = slot_NPC[0 +: XLEN];
                  state_d         = STORE_WAIT;
                end
              end else begin
                cnt_d        = CNT_W'(i + 1);
                commit_npc_d = slot_NPC[i*XLEN +: XLEN];
                if (!slot_illegal[i] && slot_dest_idx[i*5 +: 5] != 5'd0) begin
                  rf_wr_en_d[i]                = 1'b1;
                  rf_wr_idx_d[i*5 +: 5]        = slot_dest_idx[i*5 +: 5];
                  rf_wr_data_d[i*XLEN +: XLEN] = slot_result[i*XLEN +: XLEN];
                end
                if (slot_illegal[i]) begin
                  go      = 1'b0;
                  state_d = HALTED;
                  error_d = ILLEGAL_INST;
                end else if (slot_halt[i]) begin
                  go      = 1'b0;
                  state_d = HALTED;
                  error_d = HALTED_ON_WFI;
                end
                if (slot_mispred[i]) begin
                  go      = 1'b0;
                  flush_d = 1'b1;
                end
              end
            end else begin
              go = 1'b0;
            end
          end
        end
        head_d = head_q + IDX_W'(cnt_d);
      end
      STORE_WAIT: begin
        store_req_d = 1'b1;
        if (store_ack) begin
          store_req_d  = 1'b0;
          cnt_d        = CNT_W'(1);
          head_d       = head_q + IDX_W'(1);
          commit_npc_d = store_npc_q;
          state_d      = RUN;
        end
      end
      default: ;
    endcase
  end

  // State and registered outputs; every output is cleared by reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= RUN;
      head_q          <= '0;
      cnt_q           <= '0;
      rf_wr_en_q      <= '0;
      rf_wr_idx_q     <= '0;
      rf_wr_data_q    <= '0;
      store_req_q     <= 1'b0;
      store_rob_idx_q <= '0;
      store_npc_q     <= '0;
      flush_q         <= 1'b0;
      commit_npc_q    <= '0;
      error_q         <= NO_ERROR;
    end else begin
      state_q         <= state_d;
      head_q          <= head_d;
      cnt_q           <= cnt_d;
      rf_wr_en_q      <= rf_wr_en_d;
      rf_wr_idx_q     <= rf_wr_idx_d;
      rf_wr_data_q    <= rf_wr_data_d;
      store_req_q     <= store_req_d;
      store_rob_idx_q <= store_rob_idx_d;
      store_npc_q     <= store_npc_d;
      flush_q         <= flush_d;
      commit_npc_q    <= commit_npc_d;
      error_q         <= error_d;
    end
  end

  assign rob_head        = head_q;
  assign commit_count    = cnt_q;
  assign rf_wr_en        = rf_wr_en_q;
  assign rf_wr_idx       = rf_wr_idx_q;
  assign rf_wr_data      = rf_wr_data_q;
  assign store_req       = store_req_q;
  assign store_rob_idx   = store_rob_idx_q;
  assign flush           = flush_q;
  assign commit_NPC      = commit_npc_q;
  assign completed_insts = 4'(cnt_q);
  assign error_status    = error_q;

`ifdef RETIRE_PERF_CNT_EN
  logic [63:0] perf_retired_q, perf_retired_d;
  logic [63:0] perf_stall_q, perf_stall_d;
  logic        stall;

  function automatic logic [63:0] sat_add64(input logic [63:0] a, input logic [63:0] b);
    logic [64:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[64] ? {64{1'b1}} : sum[63:0];
  endfunction

  // Saturating counters of retired entries and stall cycles.
  always_comb begin
    stall = (state_q == STORE_WAIT) ||
            (state_q == RUN && slot_valid[0] && cnt_d == '0);
    perf_retired_d = sat_add64(perf_retired_q, 64'(cnt_d));
    perf_stall_d   = sat_add64(perf_stall_q, {63'd0, stall});
  end

  // Performance counter registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      perf_retired_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      perf_retired_q <= perf_retired_d;
      perf_stall_q   <= perf_stall_d;
    end
  end

  assign perf_retired      = perf_retired_q;
  assign perf_stall_cycles = perf_stall_q;
`endif

endmodule

// File: tb/tb_retire_multi.sv
// Bench for retire_multi: a hand-written vector table, directed corner
// sequences and randomized slots checked against a behavioural model.
module tb_retire_multi;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [1:0]  slot_valid, slot_done, slot_halt, slot_illegal, slot_store, slot_mispred;
  logic [9:0]  slot_rob_idx, slot_dest_idx;
  logic [63:0] slot_result, slot_NPC;
  logic        store_ack;
  logic [4:0]  rob_head, store_rob_idx;
  logic [1:0]  commit_count, rf_wr_en, error_status;
  logic [9:0]  rf_wr_idx;
  logic [63:0] rf_wr_data;
  logic        store_req, flush;
  logic [31:0] commit_NPC;
  logic [3:0]  completed_insts;
`ifdef RETIRE_PERF_CNT_EN
  logic [63:0] perf_retired, perf_stall_cycles;
`endif

  retire_multi dut (
    .clock(clock), .reset_n(reset_n),
    .slot_valid(slot_valid), .slot_done(slot_done), .slot_rob_idx(slot_rob_idx),
    .slot_dest_idx(slot_dest_idx), .slot_result(slot_result), .slot_NPC(slot_NPC),
    .slot_halt(slot_halt), .slot_illegal(slot_illegal), .slot_store(slot_store),
    .slot_mispred(slot_mispred), .store_ack(store_ack),
    .rob_head(rob_head), .commit_count(commit_count), .rf_wr_en(rf_wr_en),
    .rf_wr_idx(rf_wr_idx), .rf_wr_data(rf_wr_data), .store_req(store_req),
    .store_rob_idx(store_rob_idx), .flush(flush), .commit_NPC(commit_NPC),
    .completed_insts(completed_insts), .error_status(error_status)
`ifdef RETIRE_PERF_CNT_EN
    , .perf_retired(perf_retired), .perf_stall_cycles(perf_stall_cycles)
`endif
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model state
  localparam int M_RUN = 0, M_WAIT = 1, M_HALT = 2;
  int          m_head, m_mode;
  logic [1:0]  m_err;
  logic [4:0]  m_sidx;
  logic [31:0] m_snpc;
  longint unsigned m_pret, m_pstall;

  typedef struct packed {
    logic [1:0]  cnt;
    logic [4:0]  head;
    logic [1:0]  en;
    logic [9:0]  widx;
    logic [63:0] wdata;
    logic        sreq;
    logic [4:0]  sidx;
    logic        flush;
    logic [31:0] npc;
    logic [1:0]  err;
  } exp_t;

  typedef struct {
    logic [1:0]  v, d, st, mp;
    logic [4:0]  i0, i1, d0, d1;
    logic [31:0] r0, r1;
    logic [1:0]  cnt;
    logic [4:0]  head;
    logic [1:0]  en;
    logic        fl;
    logic [31:0] npc;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] npc_of(input logic [4:0] idx);
    return 32'h1000 + {25'd0, idx, 2'b00};
  endfunction

  task automatic clear_slots();
    slot_valid = '0; slot_done = '0; slot_halt = '0; slot_illegal = '0;
    slot_store = '0; slot_mispred = '0; slot_rob_idx = '0; slot_dest_idx = '0;
    slot_result = '0; slot_NPC = '0;
  endtask

  // kind: 0 ALU, 1 halt, 2 illegal, 3 store, 4 mispredict
  task automatic set_slot(input int i, input logic [4:0] idx, input logic [4:0] dest,
                          input logic [31:0] res, input int kind);
    slot_valid[i] = 1'b1;
    slot_done[i]  = 1'b1;
    slot_rob_idx[i*5 +: 5]  = idx;
    slot_dest_idx[i*5 +: 5] = dest;
    slot_result[i*32 +: 32] = res;
    slot_NPC[i*32 +: 32]    = npc_of(idx);
    slot_halt[i]    = (kind == 1);
    slot_illegal[i] = (kind == 2);
    slot_store[i]   = (kind == 3);
    slot_mispred[i] = (kind == 4);
  endtask

  task automatic model_reset();
    m_head = 0; m_mode = M_RUN; m_err = 2'd0; m_sidx = '0; m_snpc = '0;
    m_pret = 0; m_pstall = 0;
  endtask

  // Prefix length of in-order ready slots, cut at the first special slot.
  task automatic model_eval(output exp_t e);
    int n_ok, s, cnt;
    e = '0;
    if (m_mode == M_WAIT) begin
      m_pstall++;
      if (store_ack) begin
        e.cnt = 2'd1; e.npc = m_snpc;
        m_head = (m_head + 1) % 32; m_mode = M_RUN; m_pret += 1;
      end else begin
        e.sreq = 1'b1;
      end
    end else if (m_mode == M_RUN) begin
      n_ok = 0;
      while (n_ok < 2 && slot_valid[n_ok] && slot_done[n_ok] &&
             slot_rob_idx[n_ok*5 +: 5] == 5'((m_head + n_ok) % 32)) n_ok++;
      s = -1;
      for (int j = 0; j < n_ok; j++)
        if (s < 0 && (slot_halt[j] || slot_illegal[j] || slot_mispred[j] || slot_store[j])) s = j;
      if (s < 0) cnt = n_ok;
      else if (slot_store[s]) cnt = s;
      else cnt = s + 1;
      if (s == 0 && slot_store[0]) begin
        m_mode = M_WAIT; m_sidx = 5'(m_head); m_snpc = slot_NPC[31:0]; e.sreq = 1'b1;
      end
      for (int j = 0; j < cnt; j++)
        if (!slot_illegal[j] && slot_dest_idx[j*5 +: 5] != 5'd0) begin
          e.en[j] = 1'b1;
          e.widx[j*5 +: 5]   = slot_dest_idx[j*5 +: 5];
          e.wdata[j*32 +: 32] = slot_result[j*32 +: 32];
        end
      if (cnt > 0) e.npc = slot_NPC[(cnt-1)*32 +: 32];
      if (s >= 0 && !slot_store[s]) begin
        if (slot_illegal[s]) begin m_mode = M_HALT; m_err = 2'd2; end
        else if (slot_halt[s]) begin m_mode = M_HALT; m_err = 2'd1; end
        if (slot_mispred[s]) e.flush = 1'b1;
      end
      if (slot_valid[0] && cnt == 0) m_pstall++;
      m_head = (m_head + cnt) % 32;
      m_pret += longint'(cnt);
      e.cnt = 2'(cnt);
    end
    e.head = 5'(m_head); e.sidx = m_sidx; e.err = m_err;
  endtask

  task automatic check_all(input exp_t e);
    chk("commit_count", commit_count, e.cnt);
    chk("completed_insts", completed_insts, {2'b00, e.cnt});
    chk("rob_head", rob_head, e.head);
    chk("rf_wr_en", rf_wr_en, e.en);
    for (int i = 0; i < 2; i++)
      if (e.en[i]) begin
        chk("rf_wr_idx", rf_wr_idx[i*5 +: 5], e.widx[i*5 +: 5]);
        chk("rf_wr_data", rf_wr_data[i*32 +: 32], e.wdata[i*32 +: 32]);
      end
    chk("store_req", store_req, e.sreq);
    if (e.sreq) chk("store_rob_idx", store_rob_idx, e.sidx);
    chk("flush", flush, e.flush);
    chk("commit_NPC", commit_NPC, e.npc);
    chk("error_status", error_status, e.err);
`ifdef RETIRE_PERF_CNT_EN
    chk("perf_retired", perf_retired, m_pret);
    chk("perf_stall_cycles", perf_stall_cycles, m_pstall);
`endif
  endtask

  task automatic run_cycle();
    exp_t e;
    model_eval(e);
    step();
    check_all(e);
  endtask

  // Called #1 after a rising edge; reset pulse ends well before the next edge.
  task automatic do_reset();
    reset_n = 1'b0;
    #2;
    chk("rst_head", rob_head, 5'd0);
    chk("rst_count", commit_count, 2'd0);
    chk("rst_err", error_status, 2'd0);
    chk("rst_store_req", store_req, 1'b0);
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic rand_slots();
    for (int i = 0; i < 2; i++) begin
      int k;
      logic [4:0] idx, dest;
      k    = $urandom_range(99);
      idx  = ($urandom_range(9) < 9) ? 5'((m_head + i) % 32) : 5'($urandom_range(31));
      dest = ($urandom_range(4) == 0) ? 5'd0 : 5'($urandom_range(31, 1));
      set_slot(i, idx, dest, $urandom,
               (k < 2) ? 1 : (k < 4) ? 2 : (k < 16) ? 3 : (k < 24) ? 4 : 0);
      slot_NPC[i*32 +: 32] = $urandom;
      slot_valid[i] = ($urandom_range(9) < 8);
      slot_done[i]  = ($urandom_range(9) < 8);
    end
    store_ack = ($urandom_range(9) < 4);
  endtask

  vec_t tbl[9];

  initial begin
    exp_t e;
    int   guard;
    tbl[0] = '{2'b11, 2'b11, 2'b00, 2'b00, 5'd0, 5'd1, 5'd2, 5'd5, 32'd1, 32'd9,  2'd2, 5'd2, 2'b11, 1'b0, 32'h1004};
    tbl[1] = '{2'b11, 2'b01, 2'b00, 2'b00, 5'd2, 5'd3, 5'd3, 5'd4, 32'd7, 32'd8,  2'd1, 5'd3, 2'b01, 1'b0, 32'h1008};
    tbl[2] = '{2'b11, 2'b11, 2'b00, 2'b00, 5'd3, 5'd4, 5'd2, 5'd5, 32'd1, 32'd9,  2'd2, 5'd5, 2'b11, 1'b0, 32'h1010};
    tbl[3] = '{2'b11, 2'b11, 2'b00, 2'b00, 5'd5, 5'd6, 5'd0, 5'd7, 32'd5, 32'd6,  2'd2, 5'd7, 2'b10, 1'b0, 32'h1018};
    tbl[4] = '{2'b11, 2'b11, 2'b00, 2'b00, 5'd8, 5'd7, 5'd1, 5'd1, 32'd3, 32'd3,  2'd0, 5'd7, 2'b00, 1'b0, 32'h0};
    tbl[5] = '{2'b11, 2'b11, 2'b10, 2'b00, 5'd7, 5'd8, 5'd9, 5'd9, 32'd3, 32'd4,  2'd1, 5'd8, 2'b01, 1'b0, 32'h101c};
    tbl[6] = '{2'b11, 2'b11, 2'b00, 2'b01, 5'd8, 5'd9, 5'd1, 5'd2, 32'ha, 32'hb,  2'd1, 5'd9, 2'b01, 1'b1, 32'h1020};
    tbl[7] = '{2'b00, 2'b00, 2'b00, 2'b00, 5'd9, 5'd10, 5'd1, 5'd2, 32'd0, 32'd0, 2'd0, 5'd9, 2'b00, 1'b0, 32'h0};
    tbl[8] = '{2'b10, 2'b10, 2'b00, 2'b00, 5'd9, 5'd10, 5'd1, 5'd2, 32'd0, 32'd0, 2'd0, 5'd9, 2'b00, 1'b0, 32'h0};

    reset_n = 1'b0; store_ack = 1'b0;
    clear_slots();
    model_reset();
    step(); step();
    chk("reset_head", rob_head, 5'd0);
    chk("reset_count", commit_count, 2'd0);
    chk("reset_err", error_status, 2'd0);
    chk("reset_store_req", store_req, 1'b0);
    reset_n = 1'b1;

    // Vector table
    for (int t = 0; t < 9; t++) begin
      clear_slots();
      slot_valid = tbl[t].v; slot_done = tbl[t].d;
      slot_store = tbl[t].st; slot_mispred = tbl[t].mp;
      slot_rob_idx  = {tbl[t].i1, tbl[t].i0};
      slot_dest_idx = {tbl[t].d1, tbl[t].d0};
      slot_result   = {tbl[t].r1, tbl[t].r0};
      slot_NPC      = {npc_of(tbl[t].i1), npc_of(tbl[t].i0)};
      model_eval(e);
      step();
      chk($sformatf("tbl%0d_count", t), commit_count, tbl[t].cnt);
      chk($sformatf("tbl%0d_head", t), rob_head, tbl[t].head);
      chk($sformatf("tbl%0d_wr_en", t), rf_wr_en, tbl[t].en);
      chk($sformatf("tbl%0d_flush", t), flush, tbl[t].fl);
      chk($sformatf("tbl%0d_npc", t), commit_NPC, tbl[t].npc);
      if (tbl[t].en[0]) chk($sformatf("tbl%0d_data0", t), rf_wr_data[31:0], tbl[t].r0);
      if (tbl[t].en[1]) chk($sformatf("tbl%0d_data1", t), rf_wr_data[63:32], tbl[t].r1);
    end

    // Walk the head to 31 one entry at a time, then retire across the wrap.
    guard = 0;
    while (m_head != 31 && guard < 40) begin
      clear_slots();
      set_slot(0, 5'(m_head), 5'd3, $urandom, 0);
      run_cycle();
      guard++;
    end
    chk("walk_head_31", rob_head, 5'd31);
    clear_slots();
    set_slot(0, 5'd31, 5'd4, 32'h55, 0);
    set_slot(1, 5'd0, 5'd0, 32'h66, 0);
    run_cycle();
    chk("wrap_head", rob_head, 5'd1);
    chk("wrap_count", commit_count, 2'd2);
    chk("wrap_wr_en", rf_wr_en, 2'b01);
    chk("wrap_data0", rf_wr_data[31:0], 32'h55);

    // Store handshake with a delayed ack.
    clear_slots();
    set_slot(0, 5'd1, 5'd0, 32'h0, 3);
    set_slot(1, 5'd2, 5'd6, 32'h77, 0);
    run_cycle();
    chk("st_req", store_req, 1'b1);
    chk("st_idx", store_rob_idx, 5'd1);
    chk("st_count", commit_count, 2'd0);
    for (int c = 0; c < 3; c++) begin
      run_cycle();
      chk("st_wait_req", store_req, 1'b1);
      chk("st_wait_count", commit_count, 2'd0);
      chk("st_wait_head", rob_head, 5'd1);
    end
    store_ack = 1'b1;
    run_cycle();
    chk("st_ack_count", commit_count, 2'd1);
    chk("st_ack_head", rob_head, 5'd2);
    chk("st_ack_req", store_req, 1'b0);
    store_ack = 1'b0;
    clear_slots();
    set_slot(0, 5'd2, 5'd6, 32'h77, 0);
    set_slot(1, 5'd3, 5'd7, 32'h88, 0);
    run_cycle();
    chk("post_ack_count", commit_count, 2'd2);
    chk("post_ack_head", rob_head, 5'd4);

    // Asynchronous reset while a retire is pending.
    clear_slots();
    set_slot(0, 5'd4, 5'd5, 32'h99, 0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_head", rob_head, 5'd0);
    chk("mid_rst_count", commit_count, 2'd0);
    chk("mid_rst_wr_en", rf_wr_en, 2'b00);
    chk("mid_rst_npc", commit_NPC, 32'h0);
    step();
    chk("mid_rst_head_next", rob_head, 5'd0);
    chk("mid_rst_count_next", commit_count, 2'd0);
    chk("mid_rst_err_next", error_status, 2'd0);
    chk("mid_rst_completed", completed_insts, 4'd0);
    reset_n = 1'b1;
    model_reset();

    // Randomized traffic against the model; reset whenever it halts.
    for (int c = 0; c < 600; c++) begin
      rand_slots();
      run_cycle();
      if (m_mode == M_HALT && $urandom_range(3) == 0) do_reset();
    end
    store_ack = 1'b0;
    clear_slots();
    step();
    do_reset();

    // Halt in slot 1 retires both, then nothing else retires.
    set_slot(0, 5'd0, 5'd1, 32'h11, 0);
    set_slot(1, 5'd1, 5'd2, 32'h22, 1);
    run_cycle();
    chk("halt_count", commit_count, 2'd2);
    chk("halt_err", error_status, 2'd1);
    chk("halt_wr_en", rf_wr_en, 2'b11);
    clear_slots();
    set_slot(0, 5'd2, 5'd3, 32'h33, 0);
    set_slot(1, 5'd3, 5'd4, 32'h44, 0);
    for (int c = 0; c < 3; c++) begin
      run_cycle();
      chk("halted_count", commit_count, 2'd0);
      chk("halted_err", error_status, 2'd1);
    end
    do_reset();

    // Illegal in slot 0 retires without writing; slot 1 is dropped.
    clear_slots();
    set_slot(0, 5'd0, 5'd4, 32'h44, 2);
    set_slot(1, 5'd1, 5'd5, 32'h55, 0);
    run_cycle();
    chk("ill_count", commit_count, 2'd1);
    chk("ill_wr_en", rf_wr_en, 2'b00);
    chk("ill_err", error_status, 2'd2);
    chk("ill_head", rob_head, 5'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
